// File: rtl/zif_port_pkg.sv
// Shared definitions for the ZIF port engine: MCU register map, pulse FSM
// states and the pin-to-byte sizing helpers.
package zif_port_pkg;

    localparam logic [7:0] ADDR_STATUS   = 8'h10;
    localparam logic [7:0] ADDR_DLY_LO   = 8'h11;
    localparam logic [7:0] ADDR_DLY_HI   = 8'h12;
    localparam logic [7:0] ADDR_PULSE    = 8'h13;
    localparam logic [7:0] ADDR_RAW_BASE = 8'h16;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h20;
    localparam logic [7:0] ADDR_OUT_RB   = 8'h28;
    localparam logic [7:0] ADDR_OE_BASE  = 8'h30;
    localparam logic [7:0] ADDR_OE_RB    = 8'h38;

    typedef enum logic [0:0] {
        PS_IDLE  = 1'b0,
        PS_PULSE = 1'b1
    } pulse_state_e;

    // Number of byte lanes needed to cover nr_pins pins.
    function automatic int unsigned nr_bytes(input int unsigned nr_pins);
        return (nr_pins + 32'd7) / 32'd8;
    endfunction

    // True when addr falls in [base, base+len).
    function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base,
                                       input int unsigned len);
        return (32'(addr) >= 32'(base)) && (32'(addr) < (32'(base) + len));
    endfunction

endpackage

// File: rtl/zif_port_engine_mcu_bus_sync.sv
// Synchronises the MCU strobes into the osc domain and emits single-cycle
// edge pulses.
// Ports: clk, rst_n; ale/write/read raw strobes in;
//        ale_fall, write_rise, read_fall, read_rise pulses and read_low level out.
module mcu_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ale,
    input  logic write,
    input  logic read,
    output logic ale_fall,
    output logic write_rise,
    output logic read_fall,
    output logic read_rise,
    output logic read_low
);

    // Lane order in each stage: [2]=ale, [1]=write, [0]=read; stage 0 is nearest the pins.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0] prev_q, prev_d;
    logic [2:0] last;
    logic ale_fall_q, ale_fall_d;
    logic write_rise_q, write_rise_d;
    logic read_fall_q, read_fall_d;
    logic read_rise_q, read_rise_d;
    logic read_low_q, read_low_d;

    // Shift chain and registered edge detection on the last synchroniser stage.
    always_comb begin
        last         = sync_q[SYNC_STAGES-1];
        sync_d       = {sync_q[SYNC_STAGES-2:0], {ale, write, read}};
        prev_d       = last;
        ale_fall_d   = prev_q[2] & ~last[2];
        write_rise_d = ~prev_q[1] & last[1];
        read_fall_d  = prev_q[0] & ~last[0];
        read_rise_d  = ~prev_q[0] & last[0];
        read_low_d   = ~last[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= '0;
            ale_fall_q   <= 1'b0;
            write_rise_q <= 1'b0;
            read_fall_q  <= 1'b0;
            read_rise_q  <= 1'b0;
            read_low_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            ale_fall_q   <= ale_fall_d;
            write_rise_q <= write_rise_d;
            read_fall_q  <= read_fall_d;
            read_rise_q  <= read_rise_d;
            read_low_q   <= read_low_d;
        end
    end

    assign ale_fall   = ale_fall_q;
    assign write_rise = write_rise_q;
    assign read_fall  = read_fall_q;
    assign read_rise  = read_rise_q;
    assign read_low   = read_low_q;

endmodule

// File: rtl/zif_port_engine.sv
// ZIF pin engine: MCU byte-bus register file, per-pin drive/enable registers,
// raw pin readback, programmable delay counter and a timed single-pin pulse.
// Ports: osc, rst_n; MCU bus ale/write/read/data_in -> data_out/data_oe;
//        zif_in raw pins -> zif_out/zif_oe drive vectors.
module zif_port_engine
    import zif_port_pkg::*;
#(
    parameter int unsigned NR_PINS     = 48,
    parameter int unsigned DELAY_W     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               osc,
    input  logic               rst_n,
    input  logic               ale,
    input  logic               write,
    input  logic               read,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               data_oe,
    input  logic [NR_PINS-1:0] zif_in,
    output logic [NR_PINS-1:0] zif_out,
    output logic [NR_PINS-1:0] zif_oe
);

    localparam int unsigned NR_BYTES = nr_bytes(NR_PINS);
    localparam int unsigned PAD_W    = NR_BYTES * 8;
    localparam int unsigned IDX_W    = (NR_PINS > 1) ? $clog2(NR_PINS) : 1;
    localparam int unsigned HI_W     = DELAY_W - 8;

    logic ale_fall, write_rise, read_fall, read_rise, read_low;

    mcu_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (osc),
        .rst_n      (rst_n),
        .ale        (ale),
        .write      (write),
        .read       (read),
        .ale_fall   (ale_fall),
        .write_rise (write_rise),
        .read_fall  (read_fall),
        .read_rise  (read_rise),
        .read_low   (read_low)
    );

    pulse_state_e       state_q, state_d;
    logic [7:0]         address_q, address_d;
    logic [NR_PINS-1:0] out_reg_q, out_reg_d;
    logic [NR_PINS-1:0] oe_reg_q, oe_reg_d;
    logic [DELAY_W-1:0] delay_reload_q, delay_reload_d;
    logic [DELAY_W-1:0] delay_count_q, delay_count_d;
    logic [IDX_W-1:0]   pulse_idx_q, pulse_idx_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_oe_q, data_oe_d;
    logic [NR_PINS-1:0] zif_out_q, zif_out_d;
    logic [NR_PINS-1:0] zif_oe_q, zif_oe_d;

    logic [PAD_W-1:0]   out_pad, oe_pad;
    logic [7:0]         rd_byte;
    logic               rd_hit, busy, pulse_on;
    logic [2:0]         raw_k, out_k, oe_k, out_rb_k, oe_rb_k;

    // Bus decode, delay counter, pulse FSM and registered pin/read outputs.
    always_comb begin
        state_d        = state_q;
        address_d      = address_q;
        delay_reload_d = delay_reload_q;
        delay_count_d  = delay_count_q;
        pulse_idx_d    = pulse_idx_q;
        data_out_d     = data_out_q;
        out_pad        = PAD_W'(out_reg_q);
        oe_pad         = PAD_W'(oe_reg_q);
        rd_byte        = 8'h00;

        busy     = (delay_count_q != '0);
        pulse_on = (state_q == PS_PULSE);
        raw_k    = 3'(address_q - ADDR_RAW_BASE);
        out_k    = 3'(address_q - ADDR_OUT_BASE);
        oe_k     = 3'(address_q - ADDR_OE_BASE);
        out_rb_k = 3'(address_q - ADDR_OUT_RB);
        oe_rb_k  = 3'(address_q - ADDR_OE_RB);

        if (ale_fall) begin
            address_d = data_in;
        end

        if (busy) begin
            delay_count_d = delay_count_q - DELAY_W'(1);
        end

        if (write_rise) begin
            if (address_q == ADDR_DLY_LO) begin
                delay_reload_d[7:0] = data_in;
            end else if (address_q == ADDR_DLY_HI) begin
                delay_reload_d[DELAY_W-1:8] = data_in[HI_W-1:0];
                delay_count_d               = delay_reload_d;
            end else if (address_q == ADDR_PULSE) begin
                if (!pulse_on && (32'(data_in) < NR_PINS) && (delay_reload_q != '0)) begin
                    state_d       = PS_PULSE;
                    pulse_idx_d   = IDX_W'(data_in);
                    delay_count_d = delay_reload_q;
                end
            end else if (in_window(address_q, ADDR_OUT_BASE, NR_BYTES)) begin
                out_pad[{out_k, 3'b000} +: 8] = data_in;
            end else if (in_window(address_q, ADDR_OE_BASE, NR_BYTES)) begin
                oe_pad[{oe_k, 3'b000} +: 8] = data_in;
            end
        end

        // The pulse lasts exactly as long as the counter is nonzero, so a
        // retime (or a reload of zero) during the pulse is honoured here.
        if ((state_d == PS_PULSE) && (delay_count_d == '0)) begin
            state_d = PS_IDLE;
        end

        out_reg_d = NR_PINS'(out_pad);
        oe_reg_d  = NR_PINS'(oe_pad);

        zif_out_d = out_reg_q;
        zif_oe_d  = oe_reg_q;
        if (pulse_on) begin
            zif_out_d[pulse_idx_q] = ~out_reg_q[pulse_idx_q];
            zif_oe_d[pulse_idx_q]  = 1'b1;
        end

        rd_hit = 1'b1;
        if (address_q == ADDR_STATUS) begin
            rd_byte = {6'b0, pulse_on, busy};
        end else if (in_window(address_q, ADDR_RAW_BASE, NR_BYTES)) begin
            rd_byte = PAD_W'(zif_in) >> {raw_k, 3'b000};
        end else if (in_window(address_q, ADDR_OUT_RB, NR_BYTES)) begin
            rd_byte = PAD_W'(out_reg_q) >> {out_rb_k, 3'b000};
        end else if (in_window(address_q, ADDR_OE_RB, NR_BYTES)) begin
            rd_byte = PAD_W'(oe_reg_q) >> {oe_rb_k, 3'b000};
        end else begin
            rd_hit = 1'b0;
        end

        if (read_fall) begin
            data_out_d = rd_byte;
        end
        data_oe_d = read_low & rd_hit & ~read_rise;
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= PS_IDLE;
            address_q      <= '0;
            out_reg_q      <= '0;
            oe_reg_q       <= '0;
            delay_reload_q <= '0;
            delay_count_q  <= '0;
            pulse_idx_q    <= '0;
            data_out_q     <= '0;
            data_oe_q      <= 1'b0;
            zif_out_q      <= '0;
            zif_oe_q       <= '0;
        end else begin
            state_q        <= state_d;
            address_q      <= address_d;
            out_reg_q      <= out_reg_d;
            oe_reg_q       <= oe_reg_d;
            delay_reload_q <= delay_reload_d;
            delay_count_q  <= delay_count_d;
            pulse_idx_q    <= pulse_idx_d;
            data_out_q     <= data_out_d;
            data_oe_q      <= data_oe_d;
            zif_out_q      <= zif_out_d;
            zif_oe_q       <= zif_oe_d;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign zif_out  = zif_out_q;
    assign zif_oe   = zif_oe_q;

endmodule

// File: tb/tb_zif_port_engine.sv
// Self-checking bench for zif_port_engine: a byte-level register model of the
// pin registers is compared against the pins every settled cycle, and pulse
// windows are measured against the programmed reload value.
module tb_zif_port_engine;

    localparam int unsigned NR_PINS = 48;

    logic        osc = 1'b0;
    logic        rst_n, ale, write, read;
    logic [7:0]  data_in, data_out;
    logic        data_oe;
    logic [47:0] zif_in, zif_out, zif_oe;

    always #5 osc = ~osc;

    zif_port_engine #(.NR_PINS(48), .DELAY_W(16), .SYNC_STAGES(2)) dut (
        .osc      (osc),
        .rst_n    (rst_n),
        .ale      (ale),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .zif_in   (zif_in),
        .zif_out  (zif_out),
        .zif_oe   (zif_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Register model
    logic [47:0] m_out, m_oe;
    logic [15:0] m_reload;
    logic [7:0]  m_addr;

    bit chk_en      = 1'b0;
    bit keep_chk    = 1'b0;
    bit pulse_watch = 1'b0;
    int pulse_pin   = 0;
    int pulse_cnt   = 0;
    int stray_cnt   = 0;
    logic [47:0] pm;

    logic [7:0] rd;
    logic       om, oa;
    logic [7:0] exp_raw [6] = '{8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pins against the model on every settled cycle; pulse window measurement.
    always @(negedge osc) begin
        if (chk_en) begin
            check("zif_out_model", 64'(zif_out), 64'(m_out));
            check("zif_oe_model", 64'(zif_oe), 64'(m_oe));
        end
        if (pulse_watch) begin
            pm = 48'd1 << pulse_pin;
            if (zif_out === m_out && zif_oe === m_oe) begin
                // idle cycle
            end else if (zif_out === (m_out ^ pm) && zif_oe === (m_oe | pm)) begin
                pulse_cnt++;
            end else begin
                stray_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge osc);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        data_in = a;
        ale = 1'b1;
        cyc(4);
        ale = 1'b0;
        cyc(6);
        m_addr = a;
    endtask

    task automatic bus_write(input logic [7:0] d);
        chk_en  = 1'b0;
        data_in = d;
        write   = 1'b0;
        cyc(6);
        write = 1'b1;
        cyc(6);
        if (m_addr == 8'h11) m_reload[7:0] = d;
        else if (m_addr == 8'h12) m_reload[15:8] = d;
        else if (m_addr >= 8'h20 && m_addr <= 8'h25) m_out[(int'(m_addr) - 32) * 8 +: 8] = d;
        else if (m_addr >= 8'h30 && m_addr <= 8'h35) m_oe[(int'(m_addr) - 48) * 8 +: 8] = d;
        chk_en = keep_chk;
    endtask

    task automatic bus_read(output logic [7:0] d, output logic oe_mid, output logic oe_after);
        read = 1'b0;
        cyc(6);
        d      = data_out;
        oe_mid = data_oe;
        read   = 1'b1;
        cyc(6);
        oe_after = data_oe;
    endtask

    task automatic start_watch(input int pin);
        keep_chk    = 1'b0;
        chk_en      = 1'b0;
        pulse_pin   = pin;
        pulse_cnt   = 0;
        stray_cnt   = 0;
        pulse_watch = 1'b1;
    endtask

    task automatic end_watch(input string name, input int exp_cnt);
        pulse_watch = 1'b0;
        check({name, "_width"}, 64'(pulse_cnt), 64'(exp_cnt));
        check({name, "_stray"}, 64'(stray_cnt), 64'd0);
        keep_chk = 1'b1;
        chk_en   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ale = 1'b0; write = 1'b1; read = 1'b1;
        data_in = 8'h00; zif_in = '0;
        m_out = '0; m_oe = '0; m_reload = '0; m_addr = '0;
        cyc(3);
        check("rst_zif_out", 64'(zif_out), 64'd0);
        check("rst_zif_oe", 64'(zif_oe), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_data_oe", 64'(data_oe), 64'd0);
        rst_n = 1'b1;
        cyc(6);
        keep_chk = 1'b1;
        chk_en   = 1'b1;

        // Byte 0 drive and enable registers
        bus_addr(8'h20); bus_write(8'hA5);
        bus_addr(8'h30); bus_write(8'hFF);
        check("out_b0", 64'(zif_out[7:0]), 64'hA5);
        check("oe_b0", 64'(zif_oe[7:0]), 64'hFF);
        check("out_upper", 64'(zif_out[47:8]), 64'd0);
        check("oe_upper", 64'(zif_oe[47:8]), 64'd0);
        bus_addr(8'h28); bus_read(rd, om, oa);
        check("out_rb0", 64'(rd), 64'hA5); check("out_rb0_oe", 64'(om), 64'd1);
        bus_addr(8'h38); bus_read(rd, om, oa);
        check("oe_rb0", 64'(rd), 64'hFF);
        bus_addr(8'h29); bus_read(rd, om, oa);
        check("out_rb1", 64'(rd), 64'h00); check("out_rb1_oe", 64'(om), 64'd1);

        // Raw pin readback and unmapped read
        zif_in = 48'h123456789ABC;
        for (int k = 0; k < 6; k++) begin
            bus_addr(8'(8'h16 + k));
            bus_read(rd, om, oa);
            check($sformatf("raw%0d", k), 64'(rd), 64'(exp_raw[k]));
            check($sformatf("raw%0d_oe", k), 64'(om), 64'd1);
            check($sformatf("raw%0d_oe_off", k), 64'(oa), 64'd0);
        end
        bus_addr(8'h40); bus_read(rd, om, oa);
        check("unmapped_data", 64'(rd), 64'h00);
        check("unmapped_oe", 64'(om), 64'd0);

        // Delay counter: 200-cycle count restarted after ~132 cycles
        bus_addr(8'h11); bus_write(8'hC8);
        bus_addr(8'h12); bus_write(8'h00);
        cyc(120);
        bus_write(8'h00);
        cyc(90);
        bus_addr(8'h10); bus_read(rd, om, oa);
        check("busy_after_restart", 64'(rd), 64'h01);
        check("status_oe", 64'(om), 64'd1);
        cyc(120);
        bus_read(rd, om, oa);
        check("busy_expired", 64'(rd), 64'h00);

        // 5-cycle pulse on pin 3 (out_reg[3]=0, oe_reg[3]=1)
        bus_addr(8'h11); bus_write(8'h05);
        bus_addr(8'h13);
        start_watch(3);
        bus_write(8'h03);
        cyc(10);
        end_watch("pulse5", int'(m_reload));
        check("pulse5_restore_out", 64'(zif_out[3]), 64'd0);
        check("pulse5_restore_oe", 64'(zif_oe[3]), 64'd1);

        // 10-cycle pulse: busy lasts exactly the reload value
        bus_addr(8'h11); bus_write(8'h0A);
        bus_addr(8'h13);
        start_watch(3);
        bus_write(8'h03);
        cyc(14);
        end_watch("pulse10", 10);

        // 60-cycle pulse; a second 0x13 (pin 5) during it is ignored
        bus_addr(8'h11); bus_write(8'h3C);
        bus_addr(8'h13);
        start_watch(3);
        bus_write(8'h03);
        bus_write(8'h05);
        bus_addr(8'h10); bus_read(rd, om, oa);
        check("status_in_pulse", 64'(rd), 64'h03);
        cyc(40);
        end_watch("pulse60", 60);
        bus_read(rd, om, oa);
        check("status_after_pulse", 64'(rd), 64'h00);

        // Rejected pulse requests
        bus_addr(8'h13); bus_write(8'd48);
        bus_addr(8'h10); bus_read(rd, om, oa);
        check("idx_oob_status", 64'(rd), 64'h00);
        bus_addr(8'h11); bus_write(8'h00);
        bus_addr(8'h13); bus_write(8'h02);
        bus_addr(8'h10); bus_read(rd, om, oa);
        check("zero_reload_status", 64'(rd), 64'h00);

        // Reset in the middle of a long pulse
        bus_addr(8'h12); bus_write(8'h01);
        bus_addr(8'h13);
        keep_chk = 1'b0;
        bus_write(8'h03);
        cyc(5);
        check("pre_reset_pulse", 64'(zif_out[3]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_zif_out", 64'(zif_out), 64'd0);
        check("mid_rst_zif_oe", 64'(zif_oe), 64'd0);
        check("mid_rst_data_oe", 64'(data_oe), 64'd0);
        m_out = '0; m_oe = '0; m_reload = '0; m_addr = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        keep_chk = 1'b1;
        chk_en   = 1'b1;
        bus_addr(8'h10); bus_read(rd, om, oa);
        check("post_rst_status", 64'(rd), 64'h00);

        // Fresh pulse after reset (oe_reg now 0, so enable must pulse too)
        bus_addr(8'h11); bus_write(8'h05);
        bus_addr(8'h13);
        start_watch(3);
        bus_write(8'h03);
        cyc(10);
        end_watch("pulse_post_rst", 5);
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
